tbird_lights_param: RTL and testbench
=====================================

# tbird_lights_param

Parametrised turn-signal sequencer for the lab02 tail-light controller family. It drives a configurable number of lamps per side with a progressive "fill from inner to outer" pattern and supports a prescaled step rate. An optional hazard mode flashes both sides together. The block sits between the switch inputs (left, right) and the lamp output pins and is the drop-in successor to the fixed 3+3-lamp controller.

## Interface
Parameters:
- LAMPS, default 3: lamps per side. Legal range is 1..16.
- DIV, default 1: clock cycles per sequence step. Legal range is 1..65535. DIV=1 advances the sequence every clock.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- left  input  1  left-turn request, sampled on tick cycles only.
- right  input  1  right-turn request, sampled on tick cycles only.
- lamps_l  output  LAMPS  left lamps; bit 0 is the innermost lamp.
- lamps_r  output  LAMPS  right lamps; bit 0 is the innermost lamp.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Prescaler: a free-running counter, $clog2(DIV) bits wide (minimum 1), counts 0..DIV-1 and then wraps.
  - tick = (count == DIV-1). With DIV=1, tick is constant 1.
  - The FSM advances only on tick cycles.
- FSM states:
  - IDLE
  - L(k) for k=1..LAMPS
  - R(k) for k=1..LAMPS
  - HAZ (present only with HAZARD_EN)
- Transitions, taken on tick only:
  - IDLE with left=1, right=0 → L1.
  - IDLE with right=1, left=0 → R1.
  - IDLE with left=1, right=1 → HAZ with HAZARD_EN; stays in IDLE without it.
  - IDLE with no request → IDLE.
  - L(k) → L(k+1) for k<LAMPS; L(LAMPS) → IDLE. R(k) follows the same rule.
  - These advances are unconditional: inputs are ignored mid-sequence, so a one-tick request produces a full sequence.
  - HAZ → IDLE, unconditionally.
- Outputs are decoded combinationally (Moore) from the state register:
  - L(k): lamps_l[k-1:0] = all 1, remaining bits 0; lamps_r = 0.
  - R(k): the mirror of L(k).
  - HAZ: lamps_l and lamps_r all 1.
  - IDLE: all lamps 0.
- Continuous request: holding left produces the period L1..L(LAMPS), IDLE, which is LAMPS+1 steps.
- Holding both requests with HAZARD_EN alternates HAZ and IDLE, giving a 2-step period.
- Changing the request mid-sequence (left → right) takes effect only at the next IDLE tick.

## Timing
- Reset (synchronous) forces the following at the next rising edge, overriding tick and any in-progress sequence:
  - state = IDLE, prescaler = 0
  - lamps_l = 0, lamps_r = 0, busy = 0
- Latency: a request sampled at a tick edge shows its lamp pattern immediately after that edge. Lamps are visible one cycle after the request is presented when DIV=1.
- Step duration: each non-IDLE state lasts exactly DIV cycles.
- After reset is released, the first tick occurs DIV cycles later.
- Requests asserted between ticks are not latched. They must be held through a tick cycle to be seen.
- LAMPS=1 degenerates to the sequence L1 → IDLE (blink). This case must be supported.
- Prescaler wrap-around carries no state: the counter returns to 0 and the FSM step is unaffected.
- No X on outputs at any time after the first reset edge.

## Configuration
- HAZARD_EN defined:
  - The HAZ state exists.
  - left & right together in IDLE (on a tick) → HAZ, with all 2×LAMPS lamps on for one step, then IDLE.
- HAZARD_EN undefined:
  - The HAZ state is not synthesised.
  - left & right together in IDLE keeps the FSM in IDLE with all lamps 0; busy stays 0.
  - All other behaviour is identical.

## Test plan
- Basic fill (LAMPS=3, DIV=1, reset 2 cycles then left held 1): lamps_l after successive edges = 001, 011, 111, 000, 001. lamps_r stays 000; busy = 1,1,1,0,1.
- One-tick request (right=1 for one cycle, then 0): lamps_r = 001, 011, 111, 000 and then stays 000. Asserting left during R2 is ignored.
- Prescaled timing (LAMPS=3, DIV=4, left held): each pattern 001/011/111/000 lasts exactly 4 cycles; the first change occurs 4 cycles after reset release.
- Hazard (HAZARD_EN, LAMPS=3, left=right=1 held):
  - lamps_l = lamps_r = 111, 000, 111, 000.
  - Without HAZARD_EN, all outputs remain 000000 and busy = 0.
- Reset mid-sequence (LAMPS=4, DIV=1, left held, reset=1 while lamps_l=0011): the next edge gives lamps_l = 0000 and busy = 0. After release with left still 1, the sequence restarts at 0001.
- Width sweep (LAMPS=1 and LAMPS=8, DIV=2, right held):
  - LAMPS=1 blinks 1, 0 with 2-cycle steps.
  - LAMPS=8 fills 00000001 through 11111111 over 16 cycles, then shows 0 for 2 cycles.

Source files
------------

// File: rtl/tbird_lights_param.sv
// ----------------------------------------------------------------------------
// tbird_lights_param
//   Parametrised turn-signal sequencer. Each side fills its lamps from the
//   innermost lamp outwards, one lamp per step, then returns to dark. A
//   prescaler sets the step rate. An optional hazard mode flashes both sides
//   together for one step.
//
// Parameters
//   LAMPS    lamps per side (1..16)
//   DIV      clock cycles per sequence step (1..65535)
//
// Build option
//   HAZARD_EN  when defined, left & right together in IDLE enter the HAZ
//              state (all lamps on for one step). When undefined, that
//              request combination is ignored and HAZ is not built.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   left     in   left-turn request, sampled on tick cycles only
//   right    in   right-turn request, sampled on tick cycles only
//   lamps_l  out  left lamps, bit 0 innermost (Moore decode of state)
//   lamps_r  out  right lamps, bit 0 innermost (Moore decode of state)
//   busy     out  high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module tbird_lights_param #(
   parameter int unsigned LAMPS = 3,
   parameter int unsigned DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             left,
   input  logic             right,
   output logic [LAMPS-1:0] lamps_l,
   output logic [LAMPS-1:0] lamps_r,
   output logic             busy
);

   // Prescaler width is at least one bit so DIV=1 still has a legal counter.
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   // Step index holds 1..LAMPS (0 while idle).
   localparam int unsigned SW = $clog2(LAMPS + 1);

   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
   localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);
   localparam logic [SW-1:0] STEP_ONE = SW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LEFT  = 2'd1,
`ifdef HAZARD_EN
      S_RIGHT = 2'd2,
      S_HAZ   = 2'd3
`else
      S_RIGHT = 2'd2
`endif
   } mode_t;

   logic [CW-1:0] count;
   logic          tick;

   mode_t         mode, mode_n;
   logic [SW-1:0] step, step_n;

   // Free-running step prescaler; the wrap carries no state into the FSM.
   assign tick = (count == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode <= S_IDLE;
         step <= '0;
      end else begin
         mode <= mode_n;
         step <= step_n;
      end
   end

   // Next-state logic: requests are looked at only from IDLE on a tick;
   // running sequences advance unconditionally.
   always_comb begin
      mode_n = mode;
      step_n = step;
      if (tick) begin
         case (mode)
            S_IDLE: begin
               if (left && !right) begin
                  mode_n = S_LEFT;
                  step_n = STEP_ONE;
               end else if (right && !left) begin
                  mode_n = S_RIGHT;
                  step_n = STEP_ONE;
               end
`ifdef HAZARD_EN
               else if (left && right) begin
                  mode_n = S_HAZ;
                  step_n = '0;
               end
`endif
            end
            S_LEFT, S_RIGHT: begin
               if (step == STEP_MAX) begin
                  mode_n = S_IDLE;
                  step_n = '0;
               end else begin
                  step_n = step + STEP_ONE;
               end
            end
            default: begin
               // HAZ lasts one step; any other encoding recovers to IDLE.
               mode_n = S_IDLE;
               step_n = '0;
            end
         endcase
      end
   end

   // Output decode: step k lights lamps [k-1:0] on the active side.
   always_comb begin
      lamps_l = '0;
      lamps_r = '0;
      busy    = (mode != S_IDLE);
      case (mode)
         S_LEFT: begin
            for (int i = 0; i < int'(LAMPS); i++) begin
               lamps_l[i] = (i < int'(step));
            end
         end
         S_RIGHT: begin
            for (int i = 0; i < int'(LAMPS); i++) begin
               lamps_r[i] = (i < int'(step));
            end
         end
`ifdef HAZARD_EN
         S_HAZ: begin
            lamps_l = '1;
            lamps_r = '1;
         end
`endif
         default: begin
            lamps_l = '0;
            lamps_r = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_tbird_lights_param.sv
// ----------------------------------------------------------------------------
// tb_tbird_lights_param
//   Two sequencer instances (3 lamps / every clock, 4 lamps / every 4th clock)
//   share one set of inputs. A queue-of-patterns model per instance predicts
//   the lamps; a compare process checks every cycle after the first reset.
//   Directed sections pin the model with hand-written literal patterns,
//   followed by a randomized request/reset phase.
// ----------------------------------------------------------------------------
module tb_tbird_lights_param;

   localparam int LA = 3;
   localparam int DA = 1;
   localparam int LB = 4;
   localparam int DB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic left = 1'b0;
   logic right = 1'b0;

   logic [LA-1:0] a_l, a_r;
   logic          a_busy;
   logic [LB-1:0] b_l, b_r;
   logic          b_busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tbird_lights_param #(.LAMPS(LA), .DIV(DA)) dut_a (
      .clk(clk), .reset(reset), .left(left), .right(right),
      .lamps_l(a_l), .lamps_r(a_r), .busy(a_busy)
   );

   tbird_lights_param #(.LAMPS(LB), .DIV(DB)) dut_b (
      .clk(clk), .reset(reset), .left(left), .right(right),
      .lamps_l(b_l), .lamps_r(b_r), .busy(b_busy)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Pattern of step k: low k lamps lit on the chosen side(s); {left, right}.
   function automatic logic [31:0] pat(input int k, input bit on_l, input bit on_r);
      logic [15:0] f;
      f = 16'((32'd1 << k) - 32'd1);
      return {on_l ? f : 16'd0, on_r ? f : 16'd0};
   endfunction

   // Model: a queue of patterns still to be shown; front is what is lit now.
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   int  cyca = 0, cycb = 0;
   bit  va = 1'b0, vb = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         qa.delete(); cyca = 0; va = 1'b1;
      end else begin
         if (cyca % DA == DA - 1) begin
            if (qa.size() != 0) void'(qa.pop_front());
            else if (left && !right) for (int k = 1; k <= LA; k++) qa.push_back(pat(k, 1'b1, 1'b0));
            else if (right && !left) for (int k = 1; k <= LA; k++) qa.push_back(pat(k, 1'b0, 1'b1));
`ifdef HAZARD_EN
            else if (left && right) qa.push_back(pat(LA, 1'b1, 1'b1));
`endif
         end
         cyca++;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         qb.delete(); cycb = 0; vb = 1'b1;
      end else begin
         if (cycb % DB == DB - 1) begin
            if (qb.size() != 0) void'(qb.pop_front());
            else if (left && !right) for (int k = 1; k <= LB; k++) qb.push_back(pat(k, 1'b1, 1'b0));
            else if (right && !left) for (int k = 1; k <= LB; k++) qb.push_back(pat(k, 1'b0, 1'b1));
`ifdef HAZARD_EN
            else if (left && right) qb.push_back(pat(LB, 1'b1, 1'b1));
`endif
         end
         cycb++;
      end
   end

   // Per-cycle comparison against the model, 1 time unit after the edge.
   always @(posedge clk) begin
      logic [31:0] ea, eb;
      #1;
      if (va) begin
         ea = (qa.size() != 0) ? qa[0] : 32'd0;
         check("model_a_l",    32'(a_l),    {16'd0, ea[31:16]});
         check("model_a_r",    32'(a_r),    {16'd0, ea[15:0]});
         check("model_a_busy", 32'(a_busy), 32'(qa.size() != 0));
      end
      if (vb) begin
         eb = (qb.size() != 0) ? qb[0] : 32'd0;
         check("model_b_l",    32'(b_l),    {16'd0, eb[31:16]});
         check("model_b_r",    32'(b_r),    {16'd0, eb[15:0]});
         check("model_b_busy", 32'(b_busy), 32'(qb.size() != 0));
      end
   end

   // Wait (at falling edges) until instance A is idle, bounded.
   task automatic wait_a_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = !a_busy;
      end
      check(name, 32'(ok), 32'd1);
   endtask

   int a_lit[5] = '{1, 3, 7, 0, 1};
   int a_bsy[5] = '{1, 1, 1, 0, 1};
   int b_edge[8] = '{3, 4, 8, 12, 16, 19, 20, 24};
   int b_lit[8]  = '{0, 1, 3, 7, 15, 15, 0, 1};

   initial begin
      bit ok;

      // Reset for two edges, then hold left.
      repeat (2) @(negedge clk);
      check("reset_a_l", 32'(a_l), 32'd0);
      check("reset_a_busy", 32'(a_busy), 32'd0);
      check("reset_b_l", 32'(b_l), 32'd0);
      reset = 1'b0;
      left  = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         @(posedge clk);
         #1;
         if (e <= 5) begin
            check("fill_a_l", 32'(a_l), 32'(a_lit[e-1]));
            check("fill_a_r", 32'(a_r), 32'd0);
            check("fill_a_busy", 32'(a_busy), 32'(a_bsy[e-1]));
         end
         for (int j = 0; j < 8; j++) begin
            if (b_edge[j] == e) check("div4_b_l", 32'(b_l), 32'(b_lit[j]));
         end
      end

      // Reset in the middle of a sequence (A showing 011).
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = (a_l == 3'b011);
      end
      check("wait_a_l_011", 32'(ok), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midreset_a_l", 32'(a_l), 32'd0);
      check("midreset_a_busy", 32'(a_busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("restart_a_l", 32'(a_l), 32'd1);

      // One-tick right request; left pulse during R2 is ignored.
      @(negedge clk);
      left = 1'b0;
      wait_a_idle("wait_idle_1");
      right = 1'b1;
      @(posedge clk); #1;
      check("tick_a_r1", 32'(a_r), 32'd1);
      @(negedge clk);
      right = 1'b0;
      @(posedge clk); #1;
      check("tick_a_r2", 32'(a_r), 32'd3);
      @(negedge clk);
      left = 1'b1;
      @(posedge clk); #1;
      check("tick_a_r3", 32'(a_r), 32'd7);
      check("tick_a_l_ignored", 32'(a_l), 32'd0);
      @(negedge clk);
      left = 1'b0;
      @(posedge clk); #1;
      check("tick_a_r_end", 32'(a_r), 32'd0);
      @(posedge clk); #1;
      check("tick_a_r_stay", 32'(a_r), 32'd0);
      check("tick_a_busy_stay", 32'(a_busy), 32'd0);

      // Both requests held.
      wait_a_idle("wait_idle_2");
      left  = 1'b1;
      right = 1'b1;
      for (int e = 0; e < 4; e++) begin
         @(posedge clk); #1;
`ifdef HAZARD_EN
         check("haz_a_l", 32'(a_l), (e % 2 == 0) ? 32'd7 : 32'd0);
         check("haz_a_r", 32'(a_r), (e % 2 == 0) ? 32'd7 : 32'd0);
`else
         check("haz_a_l", 32'(a_l), 32'd0);
         check("haz_a_r", 32'(a_r), 32'd0);
         check("haz_a_busy", 32'(a_busy), 32'd0);
`endif
      end
      @(negedge clk);
      left  = 1'b0;
      right = 1'b0;

      // Randomized requests with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) left  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) right = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      reset = 1'b0;
      left  = 1'b0;
      right = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
